// File: rtl/serial_config_pkg.sv
// serial_config_pkg: shared constants and FSM encoding for serial_config_rx
package serial_config_pkg;
  localparam int BYTE_W = 8;
  localparam int DEF_NREGS = 13;
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_SHIFT = 2'd1;
  localparam state_t ST_HOLD = 2'd2;
endpackage

// File: rtl/serial_config_rx_sync_edge_det.sv
// sync_edge_det: multi-stage synchroniser with rise detect, masked until the chain reflects the live pin
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clkin,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise
);
  localparam int SW = $clog2(SYNC_STAGES + 2);
  logic [SYNC_STAGES-1:0] sync;
  logic hist;
  logic armed;
  logic [SW-1:0] settle;
  assign q = sync[SYNC_STAGES-1];
  // a level already present at reset must reach the history flop before edges count
  assign armed = settle == SW'(SYNC_STAGES + 1);
  assign rise = armed & q & ~hist;
  always_ff @(posedge clkin)
    if (rst) begin
      sync <= '0;
      hist <= 1'b0;
      settle <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], d};
      hist <= q;
      settle <= armed ? settle : settle + SW'(1);
    end
endmodule

// File: rtl/serial_config_rx.sv
// serial_config_rx: serial register-frame receiver; SERCFG_BITCOUNT_EN enables frame-length checking and cfg_err
module serial_config_rx
  import serial_config_pkg::*;
#(
  parameter int NREGS = DEF_NREGS,
  parameter int SYNC_STAGES = 2
) (
  input  logic clkin,
  input  logic rst,
  input  logic p_sck_inv,
  input  logic p_sda_inv,
  input  logic p_scapt_inv,
  input  logic p_reset_inv,
  output logic [BYTE_W*NREGS-1:0] cfg_regs,
  output logic cfg_valid,
  output logic [$clog2(BYTE_W*NREGS+1)-1:0] bit_count
`ifdef SERCFG_BITCOUNT_EN
  , output logic cfg_err
`endif
);
  localparam int W = BYTE_W * NREGS;
  localparam int CW = $clog2(W + 1);
  logic sck_rise, sck_unused_q;
  logic sda_q, sda_unused_rise;
  logic scapt_rise, scapt_unused_q;
  logic sreset_q, sreset_unused_rise;
  logic [W-1:0] sh, nsh;
  logic [CW-1:0] ncnt;
  logic hold, load;
  state_t st, nst;
  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sck (
    .clkin(clkin), .rst(rst), .d(~p_sck_inv), .q(sck_unused_q), .rise(sck_rise));
  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sda (
    .clkin(clkin), .rst(rst), .d(~p_sda_inv), .q(sda_q), .rise(sda_unused_rise));
  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_scapt (
    .clkin(clkin), .rst(rst), .d(~p_scapt_inv), .q(scapt_unused_q), .rise(scapt_rise));
  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sreset (
    .clkin(clkin), .rst(rst), .d(~p_reset_inv), .q(sreset_q), .rise(sreset_unused_rise));
  // a coincident sck edge is folded in before the capture sees the register
  always_comb begin
    hold = sreset_q | (st == ST_HOLD);
    nsh = sck_rise ? {sh[W-2:0], sda_q} : sh;
    ncnt = (sck_rise && bit_count != '1) ? bit_count + CW'(1) : bit_count;
    nst = sreset_q ? ST_HOLD : (st == ST_HOLD || scapt_rise) ? ST_IDLE : sck_rise ? ST_SHIFT : st;
  end
`ifdef SERCFG_BITCOUNT_EN
  assign load = scapt_rise & (ncnt == CW'(W));
  always_ff @(posedge clkin)
    if (rst) cfg_err <= 1'b0;
    else if (~hold & scapt_rise & ~load) cfg_err <= 1'b1;
`else
  assign load = scapt_rise;
`endif
  always_ff @(posedge clkin)
    if (rst) begin
      st <= ST_IDLE;
      sh <= '0;
      bit_count <= '0;
      cfg_regs <= '0;
      cfg_valid <= 1'b0;
    end else begin
      st <= nst;
      cfg_valid <= ~hold & load;
      if (~hold & load) cfg_regs <= nsh;
      sh <= (hold | scapt_rise) ? '0 : nsh;
      bit_count <= (hold | scapt_rise) ? '0 : ncnt;
    end
endmodule

// File: tb/tb_serial_config_rx.sv
// tb_serial_config_rx: table-driven and random frame checks against a bit-queue model
module tb_serial_config_rx;
  localparam int W = 104;
  localparam int CW = 7;
`ifdef SERCFG_BITCOUNT_EN
  localparam bit CNT_EN = 1'b1;
  logic cfg_err;
`else
  localparam bit CNT_EN = 1'b0;
`endif
  logic clkin = 1'b0;
  logic rst = 1'b1;
  logic p_sck_inv = 1'b1, p_sda_inv = 1'b1, p_scapt_inv = 1'b1, p_reset_inv = 1'b1;
  logic [W-1:0] cfg_regs;
  logic cfg_valid;
  logic [CW-1:0] bit_count;
  int n_chk = 0, n_fail = 0, valid_seen = 0;
  bit bits[$];
  logic [W-1:0] exp_regs = '0;
  logic exp_err = 1'b0;
  typedef struct {
    int nbits;
    bit coincide;
    int exp_cnt;
    bit exp_valid;
  } vec_t;
  vec_t tbl[6];
  logic [7:0] frame28[13];

  serial_config_rx dut (
    .clkin(clkin), .rst(rst),
    .p_sck_inv(p_sck_inv), .p_sda_inv(p_sda_inv),
    .p_scapt_inv(p_scapt_inv), .p_reset_inv(p_reset_inv),
    .cfg_regs(cfg_regs), .cfg_valid(cfg_valid), .bit_count(bit_count)
`ifdef SERCFG_BITCOUNT_EN
    , .cfg_err(cfg_err)
`endif
  );

  always #5 clkin = ~clkin;
  always @(negedge clkin) if (cfg_valid) valid_seen++;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clkin);
    #1;
  endtask

  task automatic send_bit(input bit b);
    p_sda_inv = ~b;
    cyc(4);
    p_sck_inv = 1'b0;
    cyc(4);
    p_sck_inv = 1'b1;
    bits.push_back(b);
  endtask

  task automatic send_rand(input int n);
    for (int i = 0; i < n; i++) send_bit(1'($urandom));
  endtask

  task automatic model_capture();
    int n = bits.size();
    int cnt = n > 127 ? 127 : n;
    logic [W-1:0] v = '0;
    for (int k = 0; k < W && k < n; k++) v[k] = bits[n-1-k];
    if (!CNT_EN || cnt == W) exp_regs = v;
    else exp_err = 1'b1;
    bits.delete();
  endtask

  task automatic capture(input string name, input bit with_bit, input bit exp_valid);
    bit b = 1'($urandom);
    valid_seen = 0;
    if (with_bit) begin
      p_sda_inv = ~b;
      cyc(4);
      p_sck_inv = 1'b0;
      bits.push_back(b);
    end
    p_scapt_inv = 1'b0;
    cyc(4);
    p_sck_inv = 1'b1;
    p_scapt_inv = 1'b1;
    cyc(6);
    model_capture();
    chk({name, "_valid_pulses"}, 128'(valid_seen), 128'(exp_valid));
    chk({name, "_regs"}, 128'(cfg_regs), 128'(exp_regs));
    chk({name, "_count_cleared"}, 128'(bit_count), 128'd0);
`ifdef SERCFG_BITCOUNT_EN
    chk({name, "_err"}, 128'(cfg_err), 128'(exp_err));
`endif
  endtask

  initial begin
    tbl[0] = '{nbits: 104, coincide: 1'b0, exp_cnt: 104, exp_valid: 1'b1};
    tbl[1] = '{nbits: 103, coincide: 1'b0, exp_cnt: 103, exp_valid: !CNT_EN};
    tbl[2] = '{nbits: 130, coincide: 1'b0, exp_cnt: 127, exp_valid: !CNT_EN};
    tbl[3] = '{nbits: 104, coincide: 1'b1, exp_cnt: 103, exp_valid: 1'b1};
    tbl[4] = '{nbits: 8, coincide: 1'b0, exp_cnt: 8, exp_valid: !CNT_EN};
    tbl[5] = '{nbits: 127, coincide: 1'b0, exp_cnt: 127, exp_valid: !CNT_EN};
    frame28 = '{8'hFE, 8'h80, 8'h07, 8'h00, 8'hF8, 8'h03, 8'hC0, 8'h01,
                8'h80, 8'h0F, 8'h80, 8'h0C, 8'h0B};
    cyc(3);
    chk("rst_regs", 128'(cfg_regs), 128'd0);
    chk("rst_valid", 128'(cfg_valid), 128'd0);
    chk("rst_count", 128'(bit_count), 128'd0);
`ifdef SERCFG_BITCOUNT_EN
    chk("rst_err", 128'(cfg_err), 128'd0);
`endif
    rst = 1'b0;
    cyc(5);
    for (int i = 0; i < 13; i++)
      for (int j = 7; j >= 0; j--) send_bit(frame28[i][j]);
    chk("fixed_count", 128'(bit_count), 128'd104);
    capture("fixed", 1'b0, 1'b1);
    chk("fixed_top", 128'(cfg_regs[103:96]), 128'hFE);
    chk("fixed_low", 128'(cfg_regs[7:0]), 128'h0B);
    for (int t = 0; t < 6; t++) begin
      send_rand(tbl[t].coincide ? tbl[t].nbits - 1 : tbl[t].nbits);
      chk($sformatf("tbl%0d_count", t), 128'(bit_count), 128'(tbl[t].exp_cnt));
      capture($sformatf("tbl%0d", t), tbl[t].coincide, tbl[t].exp_valid);
    end
    send_rand(50);
    p_reset_inv = 1'b0;
    cyc(6);
    chk("sreset_count", 128'(bit_count), 128'd0);
    p_sck_inv = 1'b0;
    cyc(5);
    p_sck_inv = 1'b1;
    cyc(5);
    chk("sreset_ignores_sck", 128'(bit_count), 128'd0);
    chk("sreset_keeps_regs", 128'(cfg_regs), 128'(exp_regs));
    p_reset_inv = 1'b1;
    cyc(6);
    bits.delete();
    send_rand(104);
    capture("after_sreset", 1'b0, 1'b1);
    send_rand(60);
    rst = 1'b1;
    cyc(1);
    p_sck_inv = 1'b0;
    cyc(3);
    chk("midrst_regs", 128'(cfg_regs), 128'd0);
    chk("midrst_count", 128'(bit_count), 128'd0);
    chk("midrst_valid", 128'(cfg_valid), 128'd0);
    rst = 1'b0;
    exp_regs = '0;
    exp_err = 1'b0;
    bits.delete();
    cyc(8);
    chk("held_sck_no_edge", 128'(bit_count), 128'd0);
    p_sck_inv = 1'b1;
    cyc(4);
    send_rand(104);
    capture("after_rst", 1'b0, 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
